// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding / load-use hazard controller:
// operand select codes and the hazard FSM state type.
package fwd_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_src_mux_sel.sv
// Operand select for one ID/EX source slot; the younger EX/MEM result
// takes priority over MEM/WB, and register 0 is never forwarded.
module fwd_src_mux_sel
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_src,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        sel
);

    logic mem_match;
    logic wb_match;

    assign mem_match = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_src);
    assign wb_match  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_src);

    always_comb begin
        sel = FWD_RF;
        if (mem_match) begin
            sel = FWD_MEM;
        end else if (wb_match) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding select and load-use stall control for a 5-stage pipeline.
// Define FWD_PERF_CNT_EN to build the stall_cycles / fwd_hits counters.
//
// state | meaning
// IDLE  | no stall pending; a load-use hit stalls this cycle
// HOLD  | stall held for the remaining LOAD_LAT-1 cycles, hits ignored
module forward_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src,
    input  logic                      ex_regwrite,
    input  logic                      ex_memread,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      mem_regwrite,
    input  logic [REG_AW-1:0]         mem_rd,
    input  logic                      wb_regwrite,
    input  logic [REG_AW-1:0]         wb_rd,
    input  logic                      flush,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall,
    output logic                      bubble,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               fwd_hits
);

    localparam int CW = $clog2(LOAD_LAT) + 1;

    hz_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            src_match;
    logic            load_hit;
    logic            stall_c;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_sel
        fwd_src_mux_sel #(.REG_AW(REG_AW)) u_sel (
            .ex_src       (ex_src[k*REG_AW +: REG_AW]),
            .mem_regwrite (mem_regwrite),
            .mem_rd       (mem_rd),
            .wb_regwrite  (wb_regwrite),
            .wb_rd        (wb_rd),
            .sel          (fwd_sel[2*k +: 2])
        );
    end

    always_comb begin
        src_match = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_src_used[k] && (id_src[k*REG_AW +: REG_AW] == ex_rd)) begin
                src_match = 1'b1;
            end
        end
    end

    assign load_hit = id_valid && ex_memread && ex_regwrite && (ex_rd != '0) && src_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_hit) begin
                        stall_c = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = HOLD;
                            cnt_d   = CW'(LOAD_LAT - 1);
                        end
                    end
                end
                HOLD: begin
                    stall_c = 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Reset gates the combinational IDLE-hit path so stall is quiet during reset.
    assign stall  = stall_c && rst_n;
    assign bubble = stall;

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            fwd_hits     <= '0;
        end else begin
            if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((|fwd_sel) && (fwd_hits != 32'hFFFF_FFFF)) begin
                fwd_hits <= fwd_hits + 32'd1;
            end
        end
    end
`else
    assign stall_cycles = 32'd0;
    assign fwd_hits     = 32'd0;
`endif

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Self-checking bench for forward_hazard_ctrl: directed scenarios followed by
// random traffic, compared against a cycle-level behavioural model.
module tb_forward_hazard_ctrl;

    localparam int NS = 2;
    localparam int AW = 5;
    localparam int LL = 3;
`ifdef FWD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [NS*AW-1:0]  id_src;
    logic [NS-1:0]     id_src_used;
    logic [NS*AW-1:0]  ex_src;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [AW-1:0]     ex_rd;
    logic              mem_regwrite;
    logic [AW-1:0]     mem_rd;
    logic              wb_regwrite;
    logic [AW-1:0]     wb_rd;
    logic              flush;
    logic [2*NS-1:0]   fwd_sel;
    logic              stall;
    logic              bubble;
    logic [31:0]       stall_cycles;
    logic [31:0]       fwd_hits;

    int tests = 0;
    int fails = 0;

    // Model state: stall cycles still owed by the last accepted hit, and counters.
    int          stall_left;
    logic [31:0] m_sc;
    logic [31:0] m_fh;
    logic        exp_stall;
    logic [2*NS-1:0] exp_fwd;
    logic        obs_stall;
    int          stall_seen;

    forward_hazard_ctrl #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(LL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .ex_src       (ex_src),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .bubble       (bubble),
        .stall_cycles (stall_cycles),
        .fwd_hits     (fwd_hits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*NS-1:0] model_fwd();
        logic [2*NS-1:0] r;
        logic [AW-1:0]   s;
        r = '0;
        for (int k = 0; k < NS; k++) begin
            s = ex_src[k*AW +: AW];
            if (mem_regwrite && mem_rd != 0 && mem_rd == s)     r[2*k +: 2] = 2'b10;
            else if (wb_regwrite && wb_rd != 0 && wb_rd == s)   r[2*k +: 2] = 2'b01;
        end
        return r;
    endfunction

    function automatic logic model_hit();
        logic any;
        any = 1'b0;
        for (int k = 0; k < NS; k++)
            if (id_src_used[k] && id_src[k*AW +: AW] == ex_rd) any = 1'b1;
        return id_valid && ex_memread && ex_regwrite && (ex_rd != 0) && any;
    endfunction

    task automatic clear_inputs();
        id_valid = 1'b0; id_src = '0; id_src_used = '0; ex_src = '0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = '0;
        mem_regwrite = 1'b0; mem_rd = '0; wb_regwrite = 1'b0; wb_rd = '0;
        flush = 1'b0;
    endtask

    task automatic set_load_hit(input logic [AW-1:0] rd, input int slot, input logic used);
        id_valid = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = rd;
        id_src = '0;
        id_src[slot*AW +: AW] = rd;
        id_src_used = '0;
        id_src_used[slot] = used;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cycle_check(input string tag);
        @(negedge clk);
        if (!rst_n) begin
            stall_left = 0; m_sc = '0; m_fh = '0;
        end
        exp_fwd = model_fwd();
        if (!rst_n || flush)   exp_stall = 1'b0;
        else if (stall_left > 0) exp_stall = 1'b1;
        else                   exp_stall = model_hit();
        obs_stall = stall;
        check({tag, "/fwd_sel"}, 32'(fwd_sel), 32'(exp_fwd));
        check({tag, "/stall"}, 32'(stall), 32'(exp_stall));
        check({tag, "/bubble"}, 32'(bubble), 32'(exp_stall));
        check({tag, "/stall_cycles"}, stall_cycles, PERF ? m_sc : 32'd0);
        check({tag, "/fwd_hits"}, fwd_hits, PERF ? m_fh : 32'd0);
        @(posedge clk);
        if (!rst_n) begin
            stall_left = 0; m_sc = '0; m_fh = '0;
        end else begin
            if (exp_stall && m_sc != 32'hFFFF_FFFF) m_sc++;
            if (exp_fwd != 0 && m_fh != 32'hFFFF_FFFF) m_fh++;
            if (flush)               stall_left = 0;
            else if (stall_left > 0) stall_left--;
            else if (exp_stall)      stall_left = LL - 1;
        end
        #1;
    endtask

    initial begin
        stall_left = 0; m_sc = '0; m_fh = '0;
        clear_inputs();
        rst_n = 1'b0;

        // Reset with a live hit present: stall must stay low.
        set_load_hit(5'd9, 0, 1'b1);
        mem_regwrite = 1'b1; mem_rd = 5'd4; ex_src[AW +: AW] = 5'd4;
        cycle_check("reset");
        check("reset_fwd_comb", 32'(fwd_sel[3:2]), 32'(2'b10));
        cycle_check("reset2");
        #2 rst_n = 1'b1;
        clear_inputs();
        cycle_check("idle");

        // MEM has priority over WB for the same register.
        mem_regwrite = 1'b1; mem_rd = 5'd3; wb_regwrite = 1'b1; wb_rd = 5'd3;
        ex_src[0 +: AW] = 5'd3; ex_src[AW +: AW] = 5'd0;
        cycle_check("mem_wins");
        check("mem_wins_slot0", 32'(fwd_sel[1:0]), 32'(2'b10));
        // r0 is never forwarded.
        mem_rd = 5'd0; wb_rd = 5'd0;
        cycle_check("r0");
        check("r0_slot1", 32'(fwd_sel[3:2]), 32'(2'b00));
        wb_rd = 5'd12; ex_src[AW +: AW] = 5'd12;
        cycle_check("wb_only");
        clear_inputs();

        // Load-use hit held for the whole stall: exactly LL stall cycles.
        stall_seen = 0;
        set_load_hit(5'd7, 1, 1'b1);
        for (int i = 0; i < LL; i++) begin
            cycle_check("load_use");
            if (obs_stall) stall_seen++;
        end
        clear_inputs();
        cycle_check("load_use_end");
        if (obs_stall) stall_seen++;
        check("load_use_len", 32'(stall_seen), 32'(LL));

        // Same hit with the operand unused: no stall.
        set_load_hit(5'd7, 1, 1'b0);
        cycle_check("unused0");
        cycle_check("unused1");
        clear_inputs();

        // Flush in the second stall cycle ends the stall at once.
        set_load_hit(5'd11, 0, 1'b1);
        cycle_check("flush_c1");
        clear_inputs();
        flush = 1'b1;
        cycle_check("flush_c2");
        flush = 1'b0;
        cycle_check("flush_after");
        // Flush overrides a simultaneous hit.
        set_load_hit(5'd11, 0, 1'b1);
        flush = 1'b1;
        cycle_check("flush_hit");
        clear_inputs();
        cycle_check("flush_hit_after");

        // Reset mid-HOLD aborts the stall immediately.
        set_load_hit(5'd6, 1, 1'b1);
        cycle_check("rst_hold_c1");
        clear_inputs();
        rst_n = 1'b0;
        cycle_check("rst_hold");
        #2 rst_n = 1'b1;
        cycle_check("rst_hold_after");

        // Random traffic over a small register range to provoke matches.
        for (int i = 0; i < 400; i++) begin
            id_valid     = 1'($urandom_range(0, 3) != 0);
            id_src       = NS*AW'($urandom);
            for (int k = 0; k < NS; k++) begin
                id_src[k*AW +: AW] = AW'($urandom_range(0, 7));
                ex_src[k*AW +: AW] = AW'($urandom_range(0, 7));
            end
            id_src_used  = NS'($urandom);
            ex_regwrite  = 1'($urandom);
            ex_memread   = 1'($urandom);
            ex_rd        = AW'($urandom_range(0, 7));
            mem_regwrite = 1'($urandom);
            mem_rd       = AW'($urandom_range(0, 7));
            wb_regwrite  = 1'($urandom);
            wb_rd        = AW'($urandom_range(0, 7));
            flush        = ($urandom_range(0, 15) == 0);
            cycle_check("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
